ball_counter_chain: RTL and testbench
=====================================

Name: ball_counter_chain

Overview:
- Cycle-accurate sequential model of a generalised Turing Tumble counter board.
- Two ball hoppers, blue and red, release one ball at a time into a chain of WIDTH BIT pieces.
- A blue ball ripples as an incrementer; a red ball ripples as a decrementer.
- Lever feedback re-releases balls automatically, and an interceptor halts the board on blue overflow. This is the parametrised successor to the fixed two-bit puzzle netlists, used as a reusable board core for later puzzles.

Parameters:
- WIDTH, 4: number of BIT pieces in the chain (1..16); bit 0 is the top of the chain.
- INIT, 0: reset value of the bit chain, WIDTH bits.
- BLUE_BALLS, 8: blue hopper fill at reset (1..255).
- RED_BALLS, 8: red hopper fill at reset (0..255).

Ports:
- clk  in  1  board clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: drop the first ball.
- start_red  in  1  colour of the first ball, sampled with start (0 = blue, 1 = red).
- bits  out  WIDTH  current BIT piece states.
- blue_left  out  8  balls remaining in the blue hopper.
- red_left  out  8  balls remaining in the red hopper.
- ball_active  out  1  a ball is in the chain (DROP or RIPPLE).
- ball_red  out  1  colour of the ball in flight; holds its last value otherwise.
- ball_pos  out  $clog2(WIDTH)+1  index of the bit currently being hit.
- sink_count  out  16  balls that have finished at a lever, saturating at 0xFFFF.
- busy  out  1  state is not IDLE and not HALT.
- int_full  out  1  interceptor has caught a ball; sticky until rst.
- start_err  out  1  one-cycle pulse: start rejected.

Behaviour:
- Reset values: bits=INIT, blue_left=BLUE_BALLS, red_left=RED_BALLS, sink_count=0, ball_pos=0. ball_active, ball_red, busy, int_full and start_err are all 0. State is IDLE.
- A reset mid-ball drops the ball with no lever or sink effect.
- State machine: IDLE, DROP, RIPPLE, LEVER, HALT.
- IDLE:
  - On start, if the selected hopper is non-empty, go to DROP with ball_red=start_red.
  - On start with an empty selected hopper, pulse start_err and stay in IDLE.
- Start handling outside IDLE: start in any other state is ignored, with no start_err.
- DROP (1 cycle): decrement the ball's hopper, set ball_pos=0, go to RIPPLE.
- RIPPLE (1 cycle per bit hit): let b = bits[ball_pos]; toggle bits[ball_pos].
  - Blue ball:
    - b=0: the ball stops and goes to LEVER.
    - b=1 (carry): ball_pos+1. If ball_pos was WIDTH-1, the ball goes to the interceptor: set int_full and go to HALT.
  - Red ball:
    - b=1: the ball stops and goes to LEVER.
    - b=0 (borrow): ball_pos+1. If ball_pos was WIDTH-1 (underflow), the ball lands on the opposite lever: go to LEVER with the next colour forced to blue.
- LEVER (1 cycle): increment sink_count (saturating).
  - The next colour is the ball's own colour, or blue after a red underflow.
  - If that hopper is non-empty, go to DROP with the new colour; otherwise go to IDLE.
- HALT: absorbing; only rst leaves it. bits hold their wrapped value, which is 0 after a full carry.
- Timing per ball that stops at bit k: 1 DROP cycle + (k+1) RIPPLE cycles + 1 LEVER cycle.
- Registers update at the clock edge ending each state's cycle.
- ball_active=1 in DROP and RIPPLE; ball_pos is valid in RIPPLE.
- Width rules: hopper counts never go below 0 (DROP is entered only when non-empty). ball_pos never exceeds WIDTH-1 while RIPPLE is active.

Decomposition:
- Shared package: state enum, colour constants BLUE=0 and RED=1, and a position-width function ($clog2(WIDTH)+1).
- One natural sub-module, bit_chain_stage: one BIT piece with toggle enable, a direction input (inc/dec) and a continue output.
  - The top level instantiates WIDTH of these via generate.
  - The FSM, hoppers and counters stay in the top level.

Test Plan:
- WIDTH=3, INIT=0, BLUE_BALLS=8; start blue at cycle 0 -> first ball: DROP cycle 1, RIPPLE cycle 2, bits=001 after cycle 2, LEVER cycle 3, next DROP cycle 4. Bits step through 1..7. The 8th ball ripples 3 bits -> bits=000, int_full=1, blue_left=0, sink_count=7, state HALT.
- WIDTH=3, INIT=3'b100, RED_BALLS=2, BLUE_BALLS=1; start red -> ball 1 borrows through bits 0,1 and stops at bit 2 -> bits=011, sink_count=1. Ball 2 stops at bit 0 -> bits=010; red_left=0 -> IDLE; blue_left=1 unchanged.
- WIDTH=2, INIT=0, RED_BALLS=1, BLUE_BALLS=1; start red -> underflow -> bits=11, LEVER forces blue. Blue ball carries through both bits and overflows -> bits=00, int_full=1, HALT.
- BLUE_BALLS=1; after the board returns to IDLE with blue_left=0, pulse start blue -> start_err high for exactly 1 cycle, state stays IDLE. A start pulse while busy -> ignored, no start_err.
- Assert rst in the RIPPLE cycle of a mid-chain carry -> the next cycle shows bits=INIT, hoppers full, sink_count=0, int_full=0, IDLE. A following start runs normally.
- HALT reached; pulse start repeatedly -> no state change, no start_err. rst -> IDLE and int_full=0.

Source files
------------

// File: rtl/ball_counter_chain_pkg.sv
// Shared types and constants for the parametrised Turing Tumble counter board.
package ball_counter_chain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DROP,
        RIPPLE,
        LEVER,
        HALT
    } state_t;

    localparam logic BLUE = 1'b0;
    localparam logic RED  = 1'b1;

    // Width of ball_pos: enough to index every bit piece of the chain.
    function automatic int unsigned pos_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/ball_counter_chain_stage.sv
// One BIT piece: flips when hit, and tells the ball whether to keep falling.
module bit_chain_stage
    import ball_counter_chain_pkg::*;
#(
    parameter logic INIT_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic toggle_en,
    input  logic dec,
    output logic bit_q,
    output logic cont
);

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_q <= INIT_BIT;
        end else if (toggle_en) begin
            bit_q <= ~bit_q;
        end
    end

    // Incrementing ball carries past a 1; decrementing ball borrows past a 0.
    assign cont = (dec == RED) ? ~bit_q : bit_q;

endmodule

// File: rtl/ball_counter_chain.sv
// Counter board core: two hoppers feeding a chain of BIT pieces, with lever
// feedback and an overflow interceptor.
module ball_counter_chain
    import ball_counter_chain_pkg::*;
#(
    parameter int unsigned       WIDTH      = 4,
    parameter logic [WIDTH-1:0]  INIT       = '0,
    parameter int unsigned       BLUE_BALLS = 8,
    parameter int unsigned       RED_BALLS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         start_red,
    output logic [WIDTH-1:0]             bits,
    output logic [7:0]                   blue_left,
    output logic [7:0]                   red_left,
    output logic                         ball_active,
    output logic                         ball_red,
    output logic [pos_width(WIDTH)-1:0]  ball_pos,
    output logic [15:0]                  sink_count,
    output logic                         busy,
    output logic                         int_full,
    output logic                         start_err
);

    localparam int unsigned PW = pos_width(WIDTH);

    state_t state, state_nxt;

    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] cont_vec;
    logic             hit_cont;
    logic             last_pos;
    logic             force_blue;
    logic             sel_empty;
    logic             next_red;
    logic             next_empty;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        bit_chain_stage #(
            .INIT_BIT (INIT[i])
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .toggle_en (toggle[i]),
            .dec       (ball_red),
            .bit_q     (bits[i]),
            .cont      (cont_vec[i])
        );
    end

    // Decode ball_pos by comparison so the index width need not match WIDTH.
    always_comb begin
        toggle   = '0;
        hit_cont = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (ball_pos == PW'(i)) begin
                toggle[i] = (state == RIPPLE);
                hit_cont  = cont_vec[i];
            end
        end
    end

    assign last_pos   = (ball_pos == PW'(WIDTH - 1));
    assign sel_empty  = start_red ? (red_left == '0) : (blue_left == '0);
    assign next_red   = force_blue ? BLUE : ball_red;
    assign next_empty = next_red ? (red_left == '0) : (blue_left == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !sel_empty) state_nxt = DROP;
            DROP:    state_nxt = RIPPLE;
            RIPPLE: begin
                if (!hit_cont) begin
                    state_nxt = LEVER;
                end else if (last_pos) begin
                    state_nxt = (ball_red == BLUE) ? HALT : LEVER;
                end
            end
            LEVER:   state_nxt = next_empty ? IDLE : DROP;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ball_active = (state == DROP) || (state == RIPPLE);
        busy        = (state != IDLE) && (state != HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blue_left  <= 8'(BLUE_BALLS);
            red_left   <= 8'(RED_BALLS);
            ball_red   <= BLUE;
            ball_pos   <= '0;
            sink_count <= '0;
            int_full   <= 1'b0;
            start_err  <= 1'b0;
            force_blue <= 1'b0;
        end else begin
            start_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (sel_empty) begin
                            start_err <= 1'b1;
                        end else begin
                            ball_red   <= start_red;
                            force_blue <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (ball_red == RED) begin
                        red_left <= red_left - 8'd1;
                    end else begin
                        blue_left <= blue_left - 8'd1;
                    end
                    ball_pos <= '0;
                end
                RIPPLE: begin
                    if (hit_cont) begin
                        if (!last_pos) begin
                            ball_pos <= ball_pos + 1'b1;
                        end else if (ball_red == BLUE) begin
                            int_full <= 1'b1;
                        end else begin
                            force_blue <= 1'b1;
                        end
                    end
                end
                LEVER: begin
                    if (sink_count != '1) begin
                        sink_count <= sink_count + 16'd1;
                    end
                    if (!next_empty) begin
                        ball_red <= next_red;
                    end
                    force_blue <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_counter_chain.sv
// Directed bench: three board configurations driven from one clock and reset.
module tb_ball_counter_chain;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: WIDTH=3, INIT=0, 8 blue / 8 red
    logic       start_a = 1'b0, start_red_a = 1'b0;
    logic [2:0] bits_a, pos_a;
    logic [7:0] blue_a, red_a;
    logic       act_a, bred_a, busy_a, full_a, err_a;
    logic [15:0] sink_a;

    // B: WIDTH=3, INIT=100, 1 blue / 2 red
    logic       start_b = 1'b0, start_red_b = 1'b0;
    logic [2:0] bits_b, pos_b;
    logic [7:0] blue_b, red_b;
    logic       act_b, bred_b, busy_b, full_b, err_b;
    logic [15:0] sink_b;

    // C: WIDTH=2, INIT=0, 1 blue / 1 red
    logic       start_c = 1'b0, start_red_c = 1'b0;
    logic [1:0] bits_c, pos_c;
    logic [7:0] blue_c, red_c;
    logic       act_c, bred_c, busy_c, full_c, err_c;
    logic [15:0] sink_c;

    ball_counter_chain #(.WIDTH(3), .INIT(3'b000), .BLUE_BALLS(8), .RED_BALLS(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .start_red(start_red_a), .bits(bits_a),
        .blue_left(blue_a), .red_left(red_a), .ball_active(act_a), .ball_red(bred_a),
        .ball_pos(pos_a), .sink_count(sink_a), .busy(busy_a), .int_full(full_a),
        .start_err(err_a)
    );

    ball_counter_chain #(.WIDTH(3), .INIT(3'b100), .BLUE_BALLS(1), .RED_BALLS(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .start_red(start_red_b), .bits(bits_b),
        .blue_left(blue_b), .red_left(red_b), .ball_active(act_b), .ball_red(bred_b),
        .ball_pos(pos_b), .sink_count(sink_b), .busy(busy_b), .int_full(full_b),
        .start_err(err_b)
    );

    ball_counter_chain #(.WIDTH(2), .INIT(2'b00), .BLUE_BALLS(1), .RED_BALLS(1)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_c), .start_red(start_red_c), .bits(bits_c),
        .blue_left(blue_c), .red_left(red_c), .ball_active(act_c), .ball_red(bred_c),
        .ball_pos(pos_c), .sink_count(sink_c), .busy(busy_c), .int_full(full_c),
        .start_err(err_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic red);
        start_a = 1'b1; start_red_a = red; tick(); start_a = 1'b0;
    endtask

    task automatic pulse_b(input logic red);
        start_b = 1'b1; start_red_b = red; tick(); start_b = 1'b0;
    endtask

    task automatic pulse_c(input logic red);
        start_c = 1'b1; start_red_c = red; tick(); start_c = 1'b0;
    endtask

    initial begin
        logic [15:0] prev;

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_bits",  bits_a, 3'b000);
        chk("rst_blue",  blue_a, 8);
        chk("rst_red",   red_a, 8);
        chk("rst_sink",  sink_a, 0);
        chk("rst_pos",   pos_a, 0);
        chk("rst_act",   act_a, 0);
        chk("rst_bred",  bred_a, 0);
        chk("rst_busy",  busy_a, 0);
        chk("rst_full",  full_a, 0);
        chk("rst_err",   err_a, 0);
        chk("rst_bits_b", bits_b, 3'b100);

        // Blue count-up to overflow on A
        pulse_a(1'b0);
        chk("a_drop_act",  act_a, 1);
        chk("a_drop_busy", busy_a, 1);
        chk("a_drop_blue", blue_a, 8);
        tick();
        chk("a_rip_blue", blue_a, 7);
        chk("a_rip_pos",  pos_a, 0);
        chk("a_rip_bits", bits_a, 3'b000);
        tick();
        chk("a_lev_bits", bits_a, 3'b001);
        chk("a_lev_act",  act_a, 0);
        chk("a_lev_busy", busy_a, 1);
        chk("a_lev_sink", sink_a, 0);
        tick();
        chk("a_drop2_sink", sink_a, 1);
        chk("a_drop2_act",  act_a, 1);
        prev = sink_a;
        for (int n = 0; n < 200 && !full_a; n++) begin
            tick();
            if (sink_a != prev) begin
                chk("a_step_bits", bits_a, sink_a[2:0]);
                prev = sink_a;
            end
        end
        chk("a_ovf_full", full_a, 1);
        chk("a_ovf_bits", bits_a, 3'b000);
        chk("a_ovf_blue", blue_a, 0);
        chk("a_ovf_red",  red_a, 8);
        chk("a_ovf_sink", sink_a, 7);
        chk("a_ovf_busy", busy_a, 0);
        chk("a_ovf_act",  act_a, 0);

        // HALT ignores start
        for (int n = 0; n < 3; n++) begin
            start_a = 1'b1; tick();
            chk("a_halt_err",  err_a, 0);
            chk("a_halt_busy", busy_a, 0);
            chk("a_halt_full", full_a, 1);
            start_a = 1'b0; tick();
            chk("a_halt_bits", bits_a, 3'b000);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        chk("a_unhalt_full", full_a, 0);
        chk("a_unhalt_blue", blue_a, 8);
        chk("a_unhalt_busy", busy_a, 0);
        chk("a_unhalt_sink", sink_a, 0);

        // Reset in the RIPPLE cycle of a carry at bit 0
        pulse_a(1'b0);
        tick(); tick(); tick(); tick();
        chk("a_mid_act",  act_a, 1);
        chk("a_mid_bits", bits_a, 3'b001);
        chk("a_mid_pos",  pos_a, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("a_mrst_bits", bits_a, 3'b000);
        chk("a_mrst_blue", blue_a, 8);
        chk("a_mrst_sink", sink_a, 0);
        chk("a_mrst_full", full_a, 0);
        chk("a_mrst_busy", busy_a, 0);
        chk("a_mrst_act",  act_a, 0);
        pulse_a(1'b0);
        for (int n = 0; n < 20 && sink_a == 0; n++) tick();
        chk("a_rerun_sink", sink_a, 1);
        chk("a_rerun_bits", bits_a, 3'b001);

        // Red count-down on B, then empty-hopper starts
        pulse_b(1'b1);
        prev = sink_b;
        for (int n = 0; n < 40 && busy_b; n++) begin
            tick();
            if (sink_b != prev && sink_b == 1) chk("b_ball1_bits", bits_b, 3'b011);
            prev = sink_b;
        end
        chk("b_idle_busy", busy_b, 0);
        chk("b_bits",      bits_b, 3'b010);
        chk("b_sink",      sink_b, 2);
        chk("b_red",       red_b, 0);
        chk("b_blue",      blue_b, 1);
        chk("b_full",      full_b, 0);
        pulse_b(1'b1);
        chk("b_rerr_hi",   err_b, 1);
        chk("b_rerr_busy", busy_b, 0);
        tick();
        chk("b_rerr_lo",   err_b, 0);
        pulse_b(1'b0);
        start_b = 1'b1; start_red_b = 1'b0; tick(); start_b = 1'b0;
        chk("b_busy_start_err", err_b, 0);
        for (int n = 0; n < 40 && busy_b; n++) tick();
        chk("b_blue_busy", busy_b, 0);
        chk("b_blue_bits", bits_b, 3'b011);
        chk("b_blue_left", blue_b, 0);
        chk("b_blue_sink", sink_b, 3);
        pulse_b(1'b0);
        chk("b_berr_hi",   err_b, 1);
        chk("b_berr_busy", busy_b, 0);
        tick();
        chk("b_berr_lo",   err_b, 0);
        chk("b_berr_bits", bits_b, 3'b011);

        // Red underflow forces blue, which then overflows, on C
        pulse_c(1'b1);
        prev = sink_c;
        for (int n = 0; n < 40 && !full_c; n++) begin
            tick();
            if (sink_c != prev) chk("c_uflow_bits", bits_c, 2'b11);
            prev = sink_c;
        end
        chk("c_full", full_c, 1);
        chk("c_bits", bits_c, 2'b00);
        chk("c_sink", sink_c, 1);
        chk("c_blue", blue_c, 0);
        chk("c_red",  red_c, 0);
        chk("c_busy", busy_c, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
